mac_aging_ctrl: RTL and testbench
=================================

// Module: mac_aging_ctrl
// PURPOSE
//  Aging sweep controller for the switch MAC address table.
//  - Each 1-cycle tick from the periodic aging timer starts one sweep of every table entry.
//  - Per entry, a valid entry's age is decremented; an entry already at age 0 is invalidated.
//  - Shares the table RAM port with the lookup/learning engine, which always has priority.
// PARAMETERS
//  ADDR_W  10    table address width
//  DEPTH   1024  entries swept per pass; DEPTH <= 2**ADDR_W, addresses 0..DEPTH-1
//  AGE_W   2     age field width; entry word = {valid, age[AGE_W-1:0]}
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         asynchronous reset, active-low
//  tick       in   1         1-cycle aging pulse from the timer
//  aging_en   in   1         0 = ticks ignored and any running sweep aborts
//  tbl_busy   in   1         lookup/learning engine owns the table port this cycle
//  tbl_rd     out  1         table read strobe
//  tbl_wr     out  1         table write strobe
//  tbl_addr   out  ADDR_W    table address for tbl_rd / tbl_wr
//  tbl_rdata  in   AGE_W+1   read data, valid exactly 1 cycle after tbl_rd
//  tbl_wdata  out  AGE_W+1   write-back data
//  lrn_wr     in   1         learning engine writes a table entry this cycle
//  lrn_addr   in   ADDR_W    address of that learning write
//  sweep_busy out  1         high from sweep start until the cycle after the last write-back
//  sweep_done out  1         1-cycle pulse when a sweep completes normally (not on abort)
//  overrun    out  1         sticky; set when a tick arrives while a tick is already pending
//  ovr_clr    in   1         clears overrun (set has priority if both in same cycle)
// BEHAVIOUR
//  Reset: state IDLE, cur addr 0, pending 0.
//  - All outputs 0: tbl_rd, tbl_wr, tbl_addr, tbl_wdata, sweep_busy, sweep_done, overrun.
//  States:
//  - IDLE: tick & aging_en -> RD, cur = 0, sweep_busy = 1.
//  - RD: if !tbl_busy, assert tbl_rd with tbl_addr = cur -> WAIT; otherwise hold in RD.
//  - WAIT: capture tbl_rdata (1-cycle read latency) -> WR.
//  - WR, one write-back per entry:
//    - valid=0: no write.
//    - valid=1, age>0: write {1, age-1}.
//    - valid=1, age=0: write {0, 0}.
//    - Issue the write only when !tbl_busy; otherwise hold in WR.
//    - Without a write, pass through in 1 cycle.
//  - NEXT: if cur == DEPTH-1 -> DONE; else cur += 1 -> RD.
//  - DONE: sweep_done = 1 for 1 cycle, sweep_busy = 0.
//    - pending set: clear pending and restart the sweep (-> RD, cur = 0).
//    - otherwise -> IDLE.
//  Entry cost: minimum 4 cycles per entry (RD, WAIT, WR, NEXT); tbl_busy adds stalls.
//  Learning collision:
//  - Trigger: lrn_wr with lrn_addr == cur in any cycle from the tbl_rd cycle to the write cycle, inclusive.
//  - Cancels the write-back for that entry, so a fresh learn is never overwritten.
//  - The entry is not retried; the sweep proceeds to NEXT.
//  Tick rules:
//  - Tick while sweep_busy sets pending (1 deep).
//  - Tick while pending=1 sets overrun; pending is unchanged.
//  - Tick in the DONE cycle behaves like a tick in IDLE.
//  aging_en deasserted mid-sweep:
//  - Finish any write already issued this cycle.
//  - Then go to IDLE and clear pending; no sweep_done pulse.
//  Reset mid-sweep: returns to the reset state immediately; partial sweep is abandoned.
//  Strobes: tbl_rd and tbl_wr are never high in the same cycle, and never high while tbl_busy=1.
//  Address: cur is ADDR_W bits; it does not wrap within a sweep because it stops at DEPTH-1.
// CONFIGURATION
//  AGING_STATS_EN defined:
//  - Adds output aged_cnt[15:0], which increments on each invalidating write and saturates at 16'hFFFF.
//  - Adds input stats_clr, which clears aged_cnt; an increment has priority in the same cycle.
//  - Reset value of aged_cnt: 0.
//  AGING_STATS_EN undefined: aged_cnt and stats_clr are absent; the core is unchanged.
// TESTING
//  1. DEPTH=4, entries {1,3},{0,x},{1,0},{1,1}, one tick, tbl_busy=0 -> writes addr0={1,2}, addr2={0,0}, addr3={1,0}; no write to addr1; sweep_done 1 cycle.
//  2. tbl_busy high for 5 cycles during WR of addr0 -> no strobes while busy; write occurs the first cycle after busy drops; contents as in test 1.
//  3. lrn_wr to addr2 in the WAIT cycle of addr2 -> no write to addr2; addr3 is still written {1,0}.
//  4. Tick mid-sweep -> second sweep starts right after sweep_done; with a third tick before that -> overrun=1 until ovr_clr.
//  5. aging_en dropped while in RD of addr1 -> IDLE, sweep_busy=0, no sweep_done; later tick restarts at addr 0.
//  6. AGING_STATS_EN with 2 expiring entries over one sweep -> aged_cnt=2; stats_clr -> 0; reset mid-sweep -> all outputs 0.

Source files
------------

// File: rtl/mac_aging_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_aging_ctrl
// Description : Aging sweep controller for the switch MAC table. Each timer
//               tick sweeps all entries, decrementing ages and invalidating
//               expired entries. Optional macro AGING_STATS_EN adds aged_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_aging_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int AGE_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AGING_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       aged_cnt,
`endif
  input  logic              tick,
  input  logic              aging_en,
  input  logic              tbl_busy,
  output logic              tbl_rd,
  output logic              tbl_wr,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [AGE_W:0]    tbl_rdata,
  output logic [AGE_W:0]    tbl_wdata,
  input  logic              lrn_wr,
  input  logic [ADDR_W-1:0] lrn_addr,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              overrun,
  input  logic              ovr_clr
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [AGE_W:0]      r_entry;
  logic                r_coll;
  logic                r_pending;
  logic                r_overrun;
  logic                w_rd;
  logic                w_wr;
  logic                w_active;
  logic                w_tick;
  logic                w_hit;
  logic                w_need_wr;
  logic [AGE_W-1:0]    w_age;
  logic [AGE_W:0]      w_aged;

  assign w_tick    = tick & aging_en;
  assign w_hit     = lrn_wr && (lrn_addr == r_cur);
  assign w_active  = (r_state == ST_RD) || (r_state == ST_WAIT) ||
                     (r_state == ST_WR) || (r_state == ST_NEXT);
  assign w_age     = r_entry[AGE_W-1:0];
  assign w_aged    = (w_age != '0) ? {1'b1, w_age - AGE_W'(1)} : '0;
  // A learn anywhere from the read through the write cycle wins over aging.
  assign w_need_wr = r_entry[AGE_W] && !r_coll && !w_hit;

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_tick) w_next = ST_RD;
      ST_RD: begin
        if (!aging_en) begin
          w_next = ST_IDLE;
        end else if (!tbl_busy) begin
          w_rd   = 1'b1;
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: w_next = aging_en ? ST_WR : ST_IDLE;
      ST_WR: begin
        if (w_need_wr) begin
          if (!tbl_busy) begin
            w_wr   = 1'b1;
            w_next = aging_en ? ST_NEXT : ST_IDLE;
          end else if (!aging_en) begin
            w_next = ST_IDLE;
          end
        end else begin
          w_next = aging_en ? ST_NEXT : ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (!aging_en)            w_next = ST_IDLE;
        else if (r_cur == c_last) w_next = ST_DONE;
        else                      w_next = ST_RD;
      end
      ST_DONE: w_next = (r_pending || w_tick) && aging_en ? ST_RD : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_entry   <= '0;
      r_coll    <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_RD) begin
        if (r_state == ST_NEXT) r_cur <= r_cur + ADDR_W'(1);
        else                    r_cur <= '0;
      end
      if (r_state == ST_WAIT) r_entry <= tbl_rdata;
      if (r_state == ST_RD)
        r_coll <= w_rd && w_hit;
      else if ((r_state == ST_WAIT) || (r_state == ST_WR))
        r_coll <= r_coll | w_hit;
      // The DONE cycle consumes the pending tick by restarting.
      if (!aging_en || (r_state == ST_DONE))
        r_pending <= 1'b0;
      else if (w_active && w_tick)
        r_pending <= 1'b1;
      if (w_active && w_tick && r_pending)
        r_overrun <= 1'b1;
      else if (ovr_clr)
        r_overrun <= 1'b0;
    end
  end

`ifdef AGING_STATS_EN
  logic [15:0] r_aged_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aged_cnt <= '0;
    end else if (w_wr && !w_aged[AGE_W]) begin
      if (r_aged_cnt != 16'hFFFF) r_aged_cnt <= r_aged_cnt + 16'd1;
    end else if (stats_clr) begin
      r_aged_cnt <= '0;
    end
  end
  assign aged_cnt = r_aged_cnt;
`endif

  assign tbl_rd     = w_rd;
  assign tbl_wr     = w_wr;
  assign tbl_addr   = (w_rd || w_wr) ? r_cur : '0;
  assign tbl_wdata  = w_wr ? w_aged : '0;
  assign sweep_busy = w_active;
  assign sweep_done = (r_state == ST_DONE);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_aging_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_aging_ctrl
// Description : Self-checking bench for mac_aging_ctrl (DEPTH=4) with a table
//               RAM model and a sweep-level write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_aging_ctrl;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int AGE_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              aging_en = 1'b1;
  logic              tbl_busy = 1'b0;
  logic              tbl_rd;
  logic              tbl_wr;
  logic [ADDR_W-1:0] tbl_addr;
  logic [AGE_W:0]    tbl_rdata;
  logic [AGE_W:0]    tbl_wdata;
  logic              lrn_wr = 1'b0;
  logic [ADDR_W-1:0] lrn_addr = '0;
  logic [AGE_W:0]    lrn_data = '0;
  logic              sweep_busy;
  logic              sweep_done;
  logic              overrun;
  logic              ovr_clr = 1'b0;
`ifdef AGING_STATS_EN
  logic              stats_clr = 1'b0;
  logic [15:0]       aged_cnt;
`endif

  mac_aging_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .AGE_W(AGE_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AGING_STATS_EN
    .stats_clr(stats_clr), .aged_cnt(aged_cnt),
`endif
    .tick(tick), .aging_en(aging_en), .tbl_busy(tbl_busy),
    .tbl_rd(tbl_rd), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
    .tbl_rdata(tbl_rdata), .tbl_wdata(tbl_wdata),
    .lrn_wr(lrn_wr), .lrn_addr(lrn_addr),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] exp_rd_addr = '0;

  logic [AGE_W:0] mem    [0:7];
  logic [AGE_W:0] ld_vals[0:7];
  logic           ld_req = 1'b0;
  logic [AGE_W:0] model  [0:DEPTH-1];
  logic [ADDR_W+AGE_W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Table RAM: 1-cycle read latency; learning engine writes go straight in.
  always @(posedge clk) begin
    if (ld_req)
      for (int i = 0; i < 8; i++) mem[i] <= ld_vals[i];
    if (tbl_rd) tbl_rdata <= mem[tbl_addr];
    if (tbl_wr) mem[tbl_addr] <= tbl_wdata;
    if (lrn_wr) mem[lrn_addr] <= lrn_data;
  end

  always @(negedge clk) begin
    logic [ADDR_W+AGE_W:0] e;
    if (!rst_n) begin
      exp_rd_addr = '0;
    end else begin
      check("strobe_excl", {31'd0, tbl_rd && tbl_wr}, 32'd0);
      check("strobe_busy", {31'd0, (tbl_rd || tbl_wr) && tbl_busy}, 32'd0);
      if (tick && aging_en && !sweep_busy) exp_rd_addr = '0;
      if (tbl_rd) begin
        check("rd_addr", {29'd0, tbl_addr}, {29'd0, exp_rd_addr});
        exp_rd_addr = ADDR_W'((int'(exp_rd_addr) + 1) % DEPTH);
      end
      if (tbl_wr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_wr", {29'd0, tbl_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {29'd0, tbl_addr}, {29'd0, e[ADDR_W+AGE_W:AGE_W+1]});
          check("wr_data", {29'd0, tbl_wdata}, {29'd0, e[AGE_W:0]});
        end
      end
      if (sweep_busy) busy_cnt++;
      if (sweep_done) done_cnt++;
    end
  end

  task automatic load_mem(input logic [11:0] v);
    for (int i = 0; i < 8; i++) ld_vals[i] = (i < DEPTH) ? v[3*i +: 3] : 3'b000;
    for (int i = 0; i < DEPTH; i++) model[i] = v[3*i +: 3];
    ld_req = 1'b1;
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  // Expected write-backs of one pass over the entries selected by mask.
  task automatic push_sweep(input logic [3:0] mask);
    logic [AGE_W:0] nv;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      if (mask[i] && model[i][AGE_W]) begin
        nv = (model[i][AGE_W-1:0] != 0) ? {1'b1, model[i][AGE_W-1:0] - 2'd1} : 3'b000;
        a  = ADDR_W'(i);
        exp_q.push_back({a, nv});
        model[i] = nv;
      end
    end
  endtask

  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sweep_busy && !sweep_done) begin ok = 1'b1; break; end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < DEPTH; i++) check(name, {29'd0, mem[i]}, {29'd0, model[i]});
    check({name, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {19'd0, tbl_rd, tbl_wr, tbl_addr, tbl_wdata, sweep_busy, sweep_done, overrun}, 32'd0);
`ifdef AGING_STATS_EN
    check({name, "_aged"}, {16'd0, aged_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int d0, b0, w0;
    #1 check_outs_zero("reset_outs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 1: plain sweep over {1,3},{0,x},{1,0},{1,1}.
    load_mem({3'b101, 3'b100, 3'b010, 3'b111});
    push_sweep(4'b1111);
    d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
    do_tick();
    wait_idle("t1_idle");
    check_mem("t1_mem");
    check("t1_addr0", {29'd0, mem[0]}, 32'h6);
    check("t1_addr1", {29'd0, mem[1]}, 32'h2);
    check("t1_addr2", {29'd0, mem[2]}, 32'h0);
    check("t1_addr3", {29'd0, mem[3]}, 32'h4);
    check("t1_writes", wr_cnt - w0, 32'd3);
    check("t1_busy_cycles", busy_cnt - b0, 32'd16);
    check("t1_done", done_cnt - d0, 32'd1);

    // Test 2: table port busy for 5 cycles while addr0 wants its write.
    load_mem({3'b101, 3'b100, 3'b010, 3'b111});
    push_sweep(4'b1111);
    b0 = busy_cnt;
    do_tick();
    @(posedge clk); #1 tbl_busy = 1'b1;
    repeat (6) @(posedge clk);
    #1 tbl_busy = 1'b0;
    @(negedge clk);
    check("t2_wr_after_busy", {31'd0, tbl_wr}, 32'd1);
    check("t2_wr_addr", {29'd0, tbl_addr}, 32'd0);
    wait_idle("t2_idle");
    check_mem("t2_mem");
    check("t2_busy_cycles", busy_cnt - b0, 32'd21);

    // Test 3: learning write to addr2 during its WAIT cycle.
    load_mem({3'b101, 3'b100, 3'b111, 3'b111});
    push_sweep(4'b1011);
    do_tick();
    repeat (9) @(posedge clk);
    #1 lrn_wr = 1'b1; lrn_addr = 3'd2; lrn_data = 3'b111;
    model[2] = 3'b111;
    @(posedge clk); #1 lrn_wr = 1'b0;
    wait_idle("t3_idle");
    check_mem("t3_mem");
    check("t3_addr2_kept", {29'd0, mem[2]}, 32'h7);
    check("t3_addr3", {29'd0, mem[3]}, 32'h4);

    // Test 4: pending tick chains a second sweep, a third tick overruns.
    load_mem({3'b000, 3'b100, 3'b101, 3'b111});
    push_sweep(4'b1111);
    push_sweep(4'b1111);
    d0 = done_cnt; b0 = busy_cnt;
    do_tick();
    repeat (2) @(posedge clk);
    do_tick();
    repeat (2) @(posedge clk);
    do_tick();
    wait_idle("t4_idle");
    check_mem("t4_mem");
    check("t4_done", done_cnt - d0, 32'd2);
    check("t4_busy_cycles", busy_cnt - b0, 32'd32);
    check("t4_overrun_set", {31'd0, overrun}, 32'd1);
    repeat (3) @(posedge clk);
    #1 check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    check("t4_overrun_clr", {31'd0, overrun}, 32'd0);

    // Test 5: aging_en drops while addr1 is about to be read.
    load_mem({3'b110, 3'b110, 3'b110, 3'b110});
    push_sweep(4'b0001);
    d0 = done_cnt;
    do_tick();
    repeat (4) @(posedge clk);
    #1 aging_en = 1'b0;
    @(posedge clk); #1;
    check("t5_busy_low", {31'd0, sweep_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("t5_no_done", done_cnt - d0, 32'd0);
    check_mem("t5_partial");
    aging_en = 1'b1;
    push_sweep(4'b1111);
    do_tick();
    wait_idle("t5_idle");
    check_mem("t5_mem");
    check("t5_addr0", {29'd0, mem[0]}, 32'h4);
    check("t5_addr1", {29'd0, mem[1]}, 32'h5);
    check("t5_done", done_cnt - d0, 32'd1);

    // Test 6: expiry statistics, then reset in the middle of a sweep.
    load_mem({3'b010, 3'b110, 3'b100, 3'b100});
`ifdef AGING_STATS_EN
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    check("t6_stats_pre", {16'd0, aged_cnt}, 32'd0);
`endif
    push_sweep(4'b1111);
    do_tick();
    wait_idle("t6_idle");
    check_mem("t6_mem");
`ifdef AGING_STATS_EN
    check("t6_aged_cnt", {16'd0, aged_cnt}, 32'd2);
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    check("t6_stats_clr", {16'd0, aged_cnt}, 32'd0);
`endif
    load_mem({3'b111, 3'b111, 3'b111, 3'b111});
    do_tick();
    @(posedge clk); #1;
    check("t6_busy_before_rst", {31'd0, sweep_busy}, 32'd1);
    rst_n = 1'b0;
    #1 check_outs_zero("t6_rst_outs");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 check_outs_zero("t6_rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_after_rst", {31'd0, sweep_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
